// File: rtl/ttl_bus_arbiter_pkg.sv
// Shared definitions for the TTL bus arbiter: state encoding, select width
// and the round-robin index helper.
package ttl_bus_arbiter_pkg;

    localparam int SEL_W   = 3;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_OWN   = 2'd2,
        ST_TURN  = 2'd3
    } state_t;

    // Index after idx, wrapping at n (n is the requester count, 2..8).
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx, input int n);
        logic [SEL_W:0] sum;
        sum = {1'b0, idx} + {{SEL_W{1'b0}}, 1'b1};
        if (int'(sum) >= n) begin
            return '0;
        end
        return sum[SEL_W-1:0];
    endfunction

endpackage

// File: rtl/ttl_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request scanning from
// rr_ptr upward, modulo N_REQ.
module ttl_rr_pick
    import ttl_bus_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] rr_ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] winner_o
);

    // Zero-extended so a 3-bit index is always in range.
    logic [MAX_REQ-1:0] req_ext;
    logic [N_REQ-1:0]   hit;
    logic [SEL_W-1:0]   cand_idx [N_REQ];

    assign req_ext = MAX_REQ'(req_i);

    // Candidate gi is the requester gi places after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [SEL_W:0] sum;
            assign sum = {1'b0, rr_ptr_i} + (SEL_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (SEL_W+1)'(N_REQ))
                                ? SEL_W'(sum - (SEL_W+1)'(N_REQ))
                                : sum[SEL_W-1:0];
            assign hit[gi] = req_ext[cand_idx[gi]];
        end
    endgenerate

    // Lowest candidate offset wins; scan high-to-low so it overwrites last.
    always_comb begin
        any_o    = |hit;
        winner_o = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner_o = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/ttl_bus_arbiter.sv
// Round-robin bus arbiter/sequencer driving a 3-to-8 decoder and per-requester
// active-low buffer gates. Every tenure is framed by a SETUP cycle (decoder
// addressed, buffers off) and a TURN cycle (all buffers off), so no two
// buffers are ever enabled together. All outputs come straight from flops.
module ttl_bus_arbiter
    import ttl_bus_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,   // 2..8
    parameter int MAX_HOLD = 16   // 1..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             dec_en_n_o,
    output logic [N_REQ-1:0] oe_n_o,
    output logic             busy_o
);

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   oe_n_q, oe_n_d;
    logic               dec_en_n_q, dec_en_n_d;
    logic               busy_q, busy_d;

    logic [MAX_REQ-1:0] req_ext;
    logic               pick_any;
    logic [SEL_W-1:0]   pick_winner;

    assign req_ext = MAX_REQ'(req_i);

    ttl_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (pick_any),
        .winner_o (pick_winner)
    );

    // Next-state logic: sequence SETUP -> OWN -> TURN around each tenure.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (pick_any) begin
                    state_d  = ST_SETUP;
                    owner_d  = pick_winner;
                    rr_ptr_d = wrap_inc(pick_winner, N_REQ);
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_SETUP: begin
                // A requester that let go before its grant aborts the tenure.
                if (req_ext[owner_q]) begin
                    state_d    = ST_OWN;
                    hold_cnt_d = 8'd1;
                end else begin
                    state_d    = ST_TURN;
                end
            end
            ST_OWN: begin
                // Release and timeout collapse into the same single TURN.
                if (!req_ext[owner_q] || hold_cnt_q == HOLD_MAX) begin
                    state_d    = ST_TURN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state and next owner, so the flops line up.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign gnt_d[gi] = (state_d == ST_OWN) && (owner_d == SEL_W'(gi));
        end
    endgenerate

    assign oe_n_d     = ~gnt_d;
    assign dec_en_n_d = (state_d == ST_IDLE);
    assign busy_d     = (state_d != ST_IDLE);

    // State and output registers; reset drops all enables immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            oe_n_q     <= '1;
            dec_en_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            oe_n_q     <= oe_n_d;
            dec_en_n_q <= dec_en_n_d;
            busy_q     <= busy_d;
        end
    end

    // The owner only changes on entry to SETUP, so it doubles as the
    // decoder address and holds the last owner while idle.
    assign sel_o      = owner_q;
    assign gnt_o      = gnt_q;
    assign oe_n_o     = oe_n_q;
    assign dec_en_n_o = dec_en_n_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_ttl_bus_arbiter.sv
// Directed bench for ttl_bus_arbiter: four instances share clk/rst_n and
// differ only in MAX_HOLD (16, 3, 2, 4).
module tb_ttl_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [3:0] gnt_a, gnt_b, gnt_c, gnt_d;
    logic [3:0] oe_a, oe_b, oe_c, oe_d;
    logic [2:0] sel_a, sel_b, sel_c, sel_d;
    logic       den_a, den_b, den_c, den_d;
    logic       busy_a, busy_b, busy_c, busy_d;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ttl_bus_arbiter #(.N_REQ(4), .MAX_HOLD(16)) u_a (
        .clk(clk), .rst_n(rst_n), .req_i(req_a), .gnt_o(gnt_a), .sel_o(sel_a),
        .dec_en_n_o(den_a), .oe_n_o(oe_a), .busy_o(busy_a));
    ttl_bus_arbiter #(.N_REQ(4), .MAX_HOLD(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req_i(req_b), .gnt_o(gnt_b), .sel_o(sel_b),
        .dec_en_n_o(den_b), .oe_n_o(oe_b), .busy_o(busy_b));
    ttl_bus_arbiter #(.N_REQ(4), .MAX_HOLD(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req_i(req_c), .gnt_o(gnt_c), .sel_o(sel_c),
        .dec_en_n_o(den_c), .oe_n_o(oe_c), .busy_o(busy_c));
    ttl_bus_arbiter #(.N_REQ(4), .MAX_HOLD(4)) u_d (
        .clk(clk), .rst_n(rst_n), .req_i(req_d), .gnt_o(gnt_d), .sel_o(sel_d),
        .dec_en_n_o(den_d), .oe_n_o(oe_d), .busy_o(busy_d));

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++; if (gnt_a !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_a); end
        checks++; if (oe_a !== 4'b1111) begin failures++; $display("FAIL reset_oe got=%b exp=1111", oe_a); end
        checks++; if (den_a !== 1'b1) begin failures++; $display("FAIL reset_dec_en_n got=%b exp=1", den_a); end
        checks++; if (sel_a !== 3'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (busy_a !== 1'b0 || den_a !== 1'b1) begin failures++; $display("FAIL reset_idle busy=%b den=%b exp busy=0 den=1", busy_a, den_a); end
        $display("test_reset done");
    endtask

    task automatic test_single_grant();
        req_a = 4'b0100;
        tick();
        checks++; if (den_a !== 1'b0 || sel_a !== 3'd2 || gnt_a !== 4'b0000) begin
            failures++; $display("FAIL single_setup den=%b sel=%0d gnt=%b exp den=0 sel=2 gnt=0000", den_a, sel_a, gnt_a); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (gnt_a !== 4'b0100 || oe_a !== 4'b1011) begin
                failures++; $display("FAIL single_own cyc=%0d gnt=%b oe=%b exp gnt=0100 oe=1011", i, gnt_a, oe_a); end
        end
        req_a = 4'b0000;
        tick();
        checks++; if (gnt_a !== 4'b0000 || oe_a !== 4'b1111 || den_a !== 1'b0 || busy_a !== 1'b1) begin
            failures++; $display("FAIL single_turn gnt=%b oe=%b den=%b busy=%b exp 0000 1111 0 1", gnt_a, oe_a, den_a, busy_a); end
        tick();
        checks++; if (den_a !== 1'b1 || busy_a !== 1'b0 || sel_a !== 3'd2) begin
            failures++; $display("FAIL single_idle den=%b busy=%b sel=%0d exp 1 0 2", den_a, busy_a, sel_a); end
        $display("test_single_grant done");
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int phase, idx;
        req_b = 4'b1111;
        for (int c = 1; c <= 25; c++) begin
            tick();
            phase = (c - 1) % 5;
            idx = ((c - 1) / 5) % 4;
            exp_gnt = (phase >= 1 && phase <= 3) ? (4'b0001 << idx) : 4'b0000;
            checks++; if (gnt_b !== exp_gnt || oe_b !== ~exp_gnt) begin
                failures++; $display("FAIL rr_gnt cyc=%0d gnt=%b oe=%b exp gnt=%b", c, gnt_b, oe_b, exp_gnt); end
            checks++; if (sel_b !== 3'(idx)) begin
                failures++; $display("FAIL rr_sel cyc=%0d got=%0d exp=%0d", c, sel_b, idx); end
            checks++; if ($countones(~oe_b) > 1) begin
                failures++; $display("FAIL rr_oe_overlap cyc=%0d oe=%b", c, oe_b); end
        end
        req_b = 4'b0000;
        tick();
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL rr_drain busy=%b exp=0", busy_b); end
        $display("test_round_robin done");
    endtask

    task automatic test_sole_requester();
        logic exp_g;
        int phase;
        req_c = 4'b0001;
        for (int c = 1; c <= 16; c++) begin
            tick();
            phase = (c - 1) % 4;
            exp_g = (phase == 1 || phase == 2);
            checks++; if (gnt_c !== {3'b000, exp_g} || busy_c !== 1'b1) begin
                failures++; $display("FAIL sole_gnt cyc=%0d gnt=%b busy=%b exp gnt=000%b busy=1", c, gnt_c, busy_c, exp_g); end
        end
        req_c = 4'b0000;
        tick();
        checks++; if (busy_c !== 1'b0) begin failures++; $display("FAIL sole_drain busy=%b exp=0", busy_c); end
        $display("test_sole_requester done");
    endtask

    task automatic test_abort_pulse();
        req_a = 4'b1000;
        tick();
        req_a = 4'b0000;
        checks++; if (sel_a !== 3'd3 || den_a !== 1'b0 || gnt_a !== 4'b0000) begin
            failures++; $display("FAIL abort_setup sel=%0d den=%b gnt=%b exp 3 0 0000", sel_a, den_a, gnt_a); end
        tick();
        checks++; if (gnt_a !== 4'b0000 || den_a !== 1'b0 || busy_a !== 1'b1) begin
            failures++; $display("FAIL abort_turn gnt=%b den=%b busy=%b exp 0000 0 1", gnt_a, den_a, busy_a); end
        tick();
        checks++; if (gnt_a !== 4'b0000 || den_a !== 1'b1 || busy_a !== 1'b0 || sel_a !== 3'd3) begin
            failures++; $display("FAIL abort_idle gnt=%b den=%b busy=%b sel=%0d exp 0000 1 0 3", gnt_a, den_a, busy_a, sel_a); end
        $display("test_abort_pulse done");
    endtask

    task automatic test_async_reset();
        req_a = 4'b0010;
        tick();
        tick();
        checks++; if (gnt_a !== 4'b0010) begin failures++; $display("FAIL areset_pre gnt=%b exp=0010", gnt_a); end
        req_a = 4'b0011;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (gnt_a !== 4'b0000 || oe_a !== 4'b1111 || den_a !== 1'b1 || busy_a !== 1'b0) begin
            failures++; $display("FAIL areset_now gnt=%b oe=%b den=%b busy=%b exp 0000 1111 1 0", gnt_a, oe_a, den_a, busy_a); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (sel_a !== 3'd0 || den_a !== 1'b0) begin
            failures++; $display("FAIL areset_setup sel=%0d den=%b exp 0 0", sel_a, den_a); end
        tick();
        checks++; if (gnt_a !== 4'b0001) begin failures++; $display("FAIL areset_winner gnt=%b exp=0001", gnt_a); end
        req_a = 4'b0000;
        repeat (3) tick();
        $display("test_async_reset done");
    endtask

    task automatic test_drop_timeout();
        int n_gnt = 0;
        req_d = 4'b0100;
        tick();
        checks++; if (sel_d !== 3'd2 || gnt_d !== 4'b0000) begin
            failures++; $display("FAIL droptmo_setup sel=%0d gnt=%b exp 2 0000", sel_d, gnt_d); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (gnt_d == 4'b0100) n_gnt++;
        end
        checks++; if (n_gnt != 4) begin failures++; $display("FAIL droptmo_len got=%0d exp=4", n_gnt); end
        req_d = 4'b0000;
        tick();
        checks++; if (gnt_d !== 4'b0000 || busy_d !== 1'b1 || den_d !== 1'b0) begin
            failures++; $display("FAIL droptmo_turn gnt=%b busy=%b den=%b exp 0000 1 0", gnt_d, busy_d, den_d); end
        tick();
        checks++; if (busy_d !== 1'b0 || den_d !== 1'b1 || gnt_d !== 4'b0000) begin
            failures++; $display("FAIL droptmo_idle busy=%b den=%b gnt=%b exp 0 1 0000", busy_d, den_d, gnt_d); end
        $display("test_drop_timeout done");
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_sole_requester();
        test_abort_pulse();
        test_async_reset();
        test_drop_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
